// File: rtl/rv_fetch_unit.sv
// RV32 instruction-fetch front end: credit-based fetch queue between a
// 1-cycle synchronous instruction memory and decode, with redirect/flush.
module rv_fetch_unit #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] boot_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus_4
);
    localparam int            AW  = $clog2(DEPTH);
    localparam int            CW  = AW + 1;
    localparam logic [CW:0]   LIM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_inflight;
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_q_instr [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic            w_req;
    logic [CW:0]     w_occ;
    logic [XLEN-1:0] w_addr;

    assign id_valid = (r_count != '0);
    assign w_pop    = id_valid & id_ready;
    // A redirect drops the response of the superseded request.
    assign w_push   = r_inflight & ~redirect_valid;

    // Occupancy counts the response still in flight so it always finds a free slot.
    assign w_occ  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_req  = rst_n & (redirect_valid | (w_occ < LIM));
    assign w_addr = redirect_valid ? (redirect_pc & ~XLEN'(3)) : r_fetch_pc;

    assign imem_req  = w_req;
    assign imem_addr = w_addr;

    assign id_instr     = id_valid ? r_q_instr[r_rptr] : NOP;
    assign id_pc        = id_valid ? r_q_pc[r_rptr] : '0;
    assign id_pc_plus_4 = id_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= boot_addr & ~XLEN'(3);
            r_inflight <= 1'b0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc <= w_addr + XLEN'(4);
            end
            if (redirect_valid) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req) begin
            r_req_addr <= w_addr;
        end
        if (w_push) begin
            r_q_instr[r_wptr] <= imem_rdata;
            r_q_pc[r_wptr]    <= r_req_addr;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: per-cycle vector table plus hand-written
// sequences for full-queue, redirect-while-full, PC wrap and mid-stream reset.
module tb_rv_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rv_fetch_unit #(.XLEN(32), .DEPTH(4), .NOP(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_addr      (boot_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus_4   (id_pc_plus_4)
    );

    // Memory returns the request address as the instruction word.
    always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEADBEEF;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_head(input string nm, input logic vld, input logic [31:0] pc);
        chk({nm, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
        chk({nm, ".pc"}, id_pc, vld ? pc : 32'd0);
        chk({nm, ".instr"}, id_instr, vld ? pc : NOP);
        chk({nm, ".pc4"}, id_pc_plus_4, (vld ? pc : 32'd0) + 32'd4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [31:0] boot, input logic rdy);
        rst_n = 1'b0;
        boot_addr = boot;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = rdy;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        //            rst   rv    rpc           rdy   req   addr          vld   pc
        vecs.push_back('{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h100,     1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h104,     1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h108,     1'b1, 32'h100});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h10C,     1'b1, 32'h104});
        vecs.push_back('{1'b1, 1'b1, 32'h2003,    1'b1, 1'b1, 32'h2000,    1'b1, 32'h108});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h2004,    1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h2008,    1'b1, 32'h2000});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h200C,    1'b1, 32'h2004});
        vecs.push_back('{1'b1, 1'b1, 32'h3000,    1'b1, 1'b1, 32'h3000,    1'b1, 32'h2008});
        vecs.push_back('{1'b1, 1'b1, 32'h4000,    1'b1, 1'b1, 32'h4000,    1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h4004,    1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h4008,    1'b1, 32'h4000});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h400C,    1'b1, 32'h4004});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h4010,    1'b1, 32'h4008});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h4014,    1'b1, 32'h4008});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h4018,    1'b1, 32'h4008});
        vecs.push_back('{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h401C,    1'b1, 32'h400C});

        reset_dut(32'h100, 1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            id_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.req", i), {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            if (vecs[i].ereq) chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].eaddr);
            chk_head($sformatf("vec%0d", i), vecs[i].evld, vecs[i].epc);
            tick();
        end

        // Fill with decode stalled: exactly four requests, then drain gaplessly.
        reset_dut(32'h100, 1'b0);
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (imem_req) begin
                chk($sformatf("full.addr%0d", nreq), imem_addr, 32'h100 + 32'(4 * nreq));
                nreq++;
            end
            tick();
        end
        chk("full.nreq", 32'(nreq), 32'd4);
        chk("full.req_off", {31'd0, imem_req}, 32'd0);
        chk_head("full.head", 1'b1, 32'h100);
        id_ready = 1'b1;
        #1;
        chk("drain.resume_req", {31'd0, imem_req}, 32'd1);
        chk("drain.resume_addr", imem_addr, 32'h110);
        for (int k = 0; k < 6; k++) begin
            chk_head($sformatf("drain%0d", k), 1'b1, 32'h100 + 32'(4 * k));
            tick();
        end

        // Redirect in the same cycle as a pop from a full queue.
        reset_dut(32'h100, 1'b0);
        repeat (8) tick();
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        #1;
        chk_head("rfull.T", 1'b1, 32'h100);
        chk("rfull.addr", imem_addr, 32'h500);
        chk("rfull.req", {31'd0, imem_req}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk_head("rfull.T1", 1'b0, 32'h0);
        tick();
        chk_head("rfull.T2", 1'b1, 32'h500);
        tick();
        chk_head("rfull.T3", 1'b1, 32'h504);

        // PC wrap, then reset with a response in flight.
        reset_dut(32'hFFFFFFF8, 1'b1);
        tick();
        tick();
        chk_head("wrap0", 1'b1, 32'hFFFFFFF8);
        tick();
        chk_head("wrap1", 1'b1, 32'hFFFFFFFC);
        tick();
        chk_head("wrap2", 1'b1, 32'h00000000);
        tick();
        chk_head("wrap3", 1'b1, 32'h00000004);
        chk("wrap3.inflight_req", {31'd0, imem_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        boot_addr = 32'h600;
        #1;
        chk("mrst.req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_head("mrst.after", 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mrst.req0", {31'd0, imem_req}, 32'd1);
        chk("mrst.addr0", imem_addr, 32'h600);
        tick();
        chk_head("mrst.c1", 1'b0, 32'h0);
        tick();
        chk_head("mrst.c2", 1'b1, 32'h600);
        tick();
        chk_head("mrst.c3", 1'b1, 32'h604);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
